// File: rtl/conv_pkg.sv
// Shared types and constants for the convolutor result window accumulator.
// Holds the result width, the largest legal dot-product value, the window
// FSM state type and the clamp helper used on every accepted result.
package conv_pkg;

   localparam int RES_W   = 4;
   localparam int MAX_DOT = 6;

   typedef enum logic {
      FILL,
      STREAM
   } win_state_t;

   // Out-of-range convolutor results are pinned to the largest legal value.
   function automatic logic [RES_W-1:0] clamp_res(input logic [RES_W-1:0] value);
      return (value > RES_W'(MAX_DOT)) ? RES_W'(MAX_DOT) : value;
   endfunction

endpackage

// File: rtl/result_history.sv
// WINDOW-deep shift register of clamped results. Shifts on load_i, flushes
// to zero on reset or clear_i, and exposes the oldest entry so the running
// sum can drop it as a new result arrives.
module result_history
   import conv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [RES_W-1:0] din_i,
   output logic [RES_W-1:0] oldest_o
);

   logic [RES_W-1:0] hist_q [DEPTH];

   // Shift new results in at slot 0; empty slots read as zero until full.
   always_ff @(posedge clock) begin
      // NOTE: this storage is reset on purpose -- the oldest slot must read 0
      // while the window is filling, so it cannot be left uninitialised.
      if (!reset || clear_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist_q[i] <= '0;
         end
      end else if (load_i) begin
         hist_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            hist_q[i] <= hist_q[i-1];
         end
      end
   end

   assign oldest_o = hist_q[DEPTH-1];

endmodule

// File: rtl/conv_window_accum.sv
// Sliding-window sum over the last WINDOW convolutor results, presented on a
// valid/ready output. Holds the FILL/STREAM FSM, the running sum and the
// output register; the history lives in result_history.
// Optional feature: define CONV_WIN_PEAK_EN to add peak_out, the largest
// sum made valid since reset or clear.
module conv_window_accum
   import conv_pkg::*;
#(
   parameter  int WINDOW = 4,
   localparam int SUM_W  = RES_W + $clog2(WINDOW)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [RES_W-1:0] res_in,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic             clear,
   output logic [SUM_W-1:0] sum_out,
   output logic             sum_valid,
   input  logic             out_ready,
   output logic [3:0]       fill_cnt,
   output logic             err
`ifdef CONV_WIN_PEAK_EN
   ,
   output logic [SUM_W-1:0] peak_out
`endif
);

   localparam logic [3:0] WIN_CNT = 4'(WINDOW);

   win_state_t       state_q, state_d;
   logic [3:0]       fill_q, fill_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [SUM_W-1:0] sum_out_q, sum_out_d;
   logic             sum_valid_q, sum_valid_d;
   logic             err_q, err_d;
`ifdef CONV_WIN_PEAK_EN
   logic [SUM_W-1:0] peak_q, peak_d;
`endif

   logic             accept;
   logic             full;
   logic             load_out;
   logic [RES_W-1:0] res_clamped;
   logic [RES_W-1:0] hist_oldest;
   logic [SUM_W-1:0] oldest_term;
   logic [SUM_W-1:0] window_sum;

   assign res_ready   = reset && (!sum_valid_q || out_ready);
   assign accept      = res_valid && res_ready;
   assign res_clamped = clamp_res(res_in);
   assign full        = (fill_q == WIN_CNT);
   assign oldest_term = full ? SUM_W'(hist_oldest) : '0;
   // Add before subtract: sum_q + 6 never exceeds 6*WINDOW + 6 < 2^SUM_W.
   assign window_sum  = sum_q + SUM_W'(res_clamped) - oldest_term;
   assign load_out    = accept && ((state_q == STREAM) || (fill_q == WIN_CNT - 4'd1));

   result_history #(
      .DEPTH(WINDOW)
   ) u_history (
      .clock   (clock),
      .reset   (reset),
      .clear_i (clear),
      .load_i  (accept && !clear),
      .din_i   (res_clamped),
      .oldest_o(hist_oldest)
   );

   // Next-state: clear flushes everything but err; otherwise accept updates
   // the running sum and, once the window is full, reloads the output.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      fill_d      = fill_q;
      sum_d       = sum_q;
      sum_out_d   = sum_out_q;
      sum_valid_d = sum_valid_q;
      err_d       = err_q;
`ifdef CONV_WIN_PEAK_EN
      peak_d      = peak_q;
`endif
      if (clear) begin
         state_d     = FILL;
         fill_d      = '0;
         sum_d       = '0;
         sum_out_d   = '0;
         sum_valid_d = 1'b0;
`ifdef CONV_WIN_PEAK_EN
         peak_d      = '0;
`endif
      end else begin
         if (accept) begin
            sum_d = window_sum;
            if (!full) begin
               fill_d = fill_q + 4'd1;
            end
            if (res_in > RES_W'(MAX_DOT)) begin
               err_d = 1'b1;
            end
         end
         if (load_out) begin
            state_d     = STREAM;
            sum_out_d   = window_sum;
            sum_valid_d = 1'b1;
`ifdef CONV_WIN_PEAK_EN
            if (window_sum > peak_q) begin
               peak_d = window_sum;
            end
`endif
         end else if (out_ready) begin
            sum_valid_d = 1'b0;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         state_q     <= FILL;
         fill_q      <= '0;
         sum_q       <= '0;
         sum_out_q   <= '0;
         sum_valid_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef CONV_WIN_PEAK_EN
         peak_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         sum_q       <= sum_d;
         sum_out_q   <= sum_out_d;
         sum_valid_q <= sum_valid_d;
         err_q       <= err_d;
`ifdef CONV_WIN_PEAK_EN
         peak_q      <= peak_d;
`endif
      end
   end

   assign sum_out   = sum_out_q;
   assign sum_valid = sum_valid_q;
   assign fill_cnt  = fill_q;
   assign err       = err_q;
`ifdef CONV_WIN_PEAK_EN
   assign peak_out  = peak_q;
`endif

endmodule

// File: tb/tb_conv_window_accum.sv
// Testbench for conv_window_accum (WINDOW=4). A queue-based window model
// predicts the outputs; a compare process checks them every cycle, and the
// directed sequences pin hand-computed values. Define CONV_WIN_PEAK_EN to
// also cover peak_out.
module tb_conv_window_accum;

   localparam int WINDOW = 4;
   localparam int SUM_W  = 4 + $clog2(WINDOW);

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [3:0]       res_in = '0;
   logic             res_valid = 1'b0;
   logic             res_ready;
   logic             clear = 1'b0;
   logic [SUM_W-1:0] sum_out;
   logic             sum_valid;
   logic             out_ready = 1'b0;
   logic [3:0]       fill_cnt;
   logic             err;
`ifdef CONV_WIN_PEAK_EN
   logic [SUM_W-1:0] peak_out;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   conv_window_accum #(.WINDOW(WINDOW)) dut (
      .clock    (clock),
      .reset    (reset),
      .res_in   (res_in),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .clear    (clear),
      .sum_out  (sum_out),
      .sum_valid(sum_valid),
      .out_ready(out_ready),
      .fill_cnt (fill_cnt),
      .err      (err)
`ifdef CONV_WIN_PEAK_EN
      ,
      .peak_out (peak_out)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Window model: results accepted since the last reset/clear, newest last.
   int q[$];
   bit exp_valid = 1'b0;
   int exp_sum   = 0;
   bit exp_err   = 1'b0;
   int exp_peak  = 0;
   int v;

   always @(posedge clock) begin
      if (!reset) begin
         q.delete();
         exp_valid = 1'b0;
         exp_sum   = 0;
         exp_err   = 1'b0;
         exp_peak  = 0;
      end else if (clear) begin
         q.delete();
         exp_valid = 1'b0;
         exp_peak  = 0;
      end else if (res_valid && (!exp_valid || out_ready)) begin
         v = (res_in > 6) ? 6 : int'(res_in);
         if (res_in > 6) exp_err = 1'b1;
         q.push_back(v);
         if (q.size() > WINDOW) void'(q.pop_front());
         if (q.size() == WINDOW) begin
            exp_sum = 0;
            foreach (q[i]) exp_sum += q[i];
            exp_valid = 1'b1;
            if (exp_sum > exp_peak) exp_peak = exp_sum;
         end
      end else if (out_ready) begin
         exp_valid = 1'b0;
      end
   end

   // Compare every cycle, half a period after the active edge.
   always @(negedge clock) begin
      check("cmp_res_ready", 32'(res_ready), 32'(reset && (!exp_valid || out_ready)));
      check("cmp_sum_valid", 32'(sum_valid), 32'(exp_valid));
      check("cmp_fill_cnt", 32'(fill_cnt), 32'(q.size()));
      check("cmp_err", 32'(err), 32'(exp_err));
      if (exp_valid) check("cmp_sum_out", 32'(sum_out), 32'(exp_sum));
`ifdef CONV_WIN_PEAK_EN
      check("cmp_peak", 32'(peak_out), 32'(exp_peak));
`endif
   end

   // Drive one cycle of inputs; returns just after the following negedge.
   task automatic apply(input logic vld, input logic [3:0] d, input logic ordy, input logic clr);
      res_valid = vld;
      res_in    = d;
      out_ready = ordy;
      clear     = clr;
      @(negedge clock);
      #1;
   endtask

   initial begin
      // Reset held with valid input: nothing accepted, outputs zero.
      reset = 1'b0;
      repeat (3) apply(1'b1, 4'd3, 1'b1, 1'b0);
      check("rst_res_ready", 32'(res_ready), 32'd0);
      check("rst_sum_valid", 32'(sum_valid), 32'd0);
      check("rst_sum_out", 32'(sum_out), 32'd0);
      check("rst_fill", 32'(fill_cnt), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      reset = 1'b1;
      res_valid = 1'b0;
      #1;
      check("rel_res_ready", 32'(res_ready), 32'd1);
      check("rel_fill", 32'(fill_cnt), 32'd0);

      // Fill then stream.
      apply(1'b1, 4'd1, 1'b1, 1'b0);
      apply(1'b1, 4'd2, 1'b1, 1'b0);
      apply(1'b1, 4'd3, 1'b1, 1'b0);
      check("fill_3", 32'(fill_cnt), 32'd3);
      check("fill_no_valid", 32'(sum_valid), 32'd0);
      apply(1'b1, 4'd4, 1'b1, 1'b0);
      check("sum_10", 32'(sum_out), 32'd10);
      check("sum_10_valid", 32'(sum_valid), 32'd1);
`ifdef CONV_WIN_PEAK_EN
      check("peak_10", 32'(peak_out), 32'd10);
`endif
      apply(1'b1, 4'd5, 1'b1, 1'b0);
      check("sum_14", 32'(sum_out), 32'd14);
`ifdef CONV_WIN_PEAK_EN
      check("peak_14", 32'(peak_out), 32'd14);
`endif
      apply(1'b1, 4'd6, 1'b1, 1'b0);
      check("sum_18", 32'(sum_out), 32'd18);
      check("fill_sat", 32'(fill_cnt), 32'd4);

      // Backpressure: output held, input stalled.
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, 4'd2, 1'b0, 1'b0);
         check("hold_ready", 32'(res_ready), 32'd0);
         check("hold_sum", 32'(sum_out), 32'd18);
         check("hold_valid", 32'(sum_valid), 32'd1);
      end
      apply(1'b1, 4'd0, 1'b1, 1'b0);
      check("handoff_sum", 32'(sum_out), 32'd15);
      check("handoff_valid", 32'(sum_valid), 32'd1);
      apply(1'b0, 4'd0, 1'b1, 1'b0);
      check("drain_valid", 32'(sum_valid), 32'd0);

      // Clamp of out-of-range results; err survives clear.
      apply(1'b0, 4'd0, 1'b1, 1'b1);
`ifdef CONV_WIN_PEAK_EN
      check("peak_clr", 32'(peak_out), 32'd0);
`endif
      apply(1'b1, 4'd6, 1'b1, 1'b0);
      apply(1'b1, 4'd6, 1'b1, 1'b0);
      apply(1'b1, 4'd7, 1'b1, 1'b0);
      check("clamp_err", 32'(err), 32'd1);
      apply(1'b1, 4'd15, 1'b1, 1'b0);
      check("clamp_sum_24", 32'(sum_out), 32'd24);
      apply(1'b0, 4'd0, 1'b1, 1'b1);
      check("clr_err_kept", 32'(err), 32'd1);
      check("clr_fill", 32'(fill_cnt), 32'd0);
      check("clr_valid", 32'(sum_valid), 32'd0);

      // Clear mid-fill leaves no residue.
      apply(1'b1, 4'd3, 1'b1, 1'b0);
      apply(1'b1, 4'd5, 1'b1, 1'b0);
      check("midfill_2", 32'(fill_cnt), 32'd2);
      apply(1'b1, 4'd5, 1'b1, 1'b1);
      check("midfill_clr", 32'(fill_cnt), 32'd0);
      for (int i = 0; i < 3; i++) apply(1'b1, 4'd1, 1'b1, 1'b0);
      check("refill_no_valid", 32'(sum_valid), 32'd0);
      apply(1'b1, 4'd1, 1'b1, 1'b0);
      check("refill_sum_4", 32'(sum_out), 32'd4);

      // Mixed traffic, checked by the compare process.
      for (int i = 0; i < 120; i++) begin
         apply(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 8)),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
